rv32m_mul_issue: RTL
====================

Name: rv32m_mul_issue

Overview:
- Requester side of the multiplier control-path handshake.
- Accepts RV32M multiply requests from the core pipeline and converts signed operands to unsigned magnitudes.
- Drives the multiplier's enable until done, selects the high or low product word with sign correction, clears the multiplier, and returns the result over a valid/ready response channel.
- Sits between the decode/execute stage and the unsigned multiplier datapath plus its control path.

Parameters:
- TIMEOUT_CYCLES, 16, maximum RUN cycles waiting for mult_done_i before aborting with an error (must be ≥ 9).
- XLEN, 32, operand and result width (64-bit product = 2·XLEN).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_funct3_i  in  3  RV32M funct3
- req_rs1_i  in  XLEN  operand A
- req_rs2_i  in  XLEN  operand B
- req_rd_i  in  5  destination register tag
- mult_en_o  out  1  enable to the multiplier control path
- mult_rst_o  out  1  active-high clear to the multiplier control path
- mult_op_a_o  out  XLEN  magnitude of A
- mult_op_b_o  out  XLEN  magnitude of B
- mult_done_i  in  1  multiplier finished
- mult_prod_i  in  2·XLEN  unsigned product
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_data_o  out  XLEN  result
- rsp_rd_o  out  5  echoed rd tag
- rsp_err_o  out  1  unsupported op or timeout

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE; all registered outputs 0; req_ready_o=0 while in reset.
  - mult_rst_o = ~rst_ni OR (state==CLEAR), so the multiplier is held in reset with this block.
- States (2-bit encoding): IDLE, RUN, CLEAR, RESP.
- IDLE:
  - req_ready_o=1. A request is accepted when req_valid_i & req_ready_o.
  - On accept, register funct3, rd and the operand magnitudes.
  - a_signed = funct3 ∈ {000,001,010}; b_signed = funct3 ∈ {000,001}.
  - Magnitude = two's complement if signed and MSB=1. 0x80000000 has magnitude 0x80000000, which fits unsigned.
  - neg = (a_signed & A[31]) ^ (b_signed & B[31]).
- Transitions out of IDLE on accept:
  - funct3[2]=1 (DIV/REM) → RESP with err=1, data=0; the multiplier is not touched.
  - Either operand is 0 → RESP with data=0, err=0 (zero shortcut, no multiplier use).
  - Otherwise → RUN, with the timeout counter cleared.
- RUN:
  - mult_en_o=1; mult_op_a_o and mult_op_b_o are stable for the whole of RUN.
  - The counter increments each cycle.
  - mult_done_i=1 → capture P = neg ? (~mult_prod_i + 1) : mult_prod_i (64-bit), then go to CLEAR.
  - Result select: funct3=000 → P[31:0]; 001/010/011 → P[63:32].
  - Counter reaches TIMEOUT_CYCLES-1 with no done → CLEAR with err=1, data=0.
  - If done and timeout occur in the same cycle, done wins.
- CLEAR:
  - mult_en_o=0, mult_rst_o=1 for exactly one cycle, returning the multiplier to its idle state.
  - Next state is RESP.
- RESP:
  - rsp_valid_o=1; data, rd and err are held stable until rsp_ready_i.
  - On rsp_valid_o & rsp_ready_i → IDLE. req_ready_o=0 (no overlap; one request in flight).
- Latency with the current 7-step multiplier core:
  - mult_done_i rises in the 8th RUN cycle; rsp_valid_o is first high 10 cycles after the accept edge.
  - Zero and unsupported shortcuts give rsp_valid_o 1 cycle after accept.
- Boundary and protocol rules:
  - mult_en_o is never asserted outside RUN.
  - mult_done_i outside RUN is ignored.
  - Reset mid-RUN aborts silently: no response, and the multiplier is cleared via mult_rst_o.
  - rsp_ready_i held high allows back-to-back requests; IDLE is still visited for one cycle per request.

Decomposition:
- Shared package holds:
  - funct3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011.
  - State encoding: IDLE=00, RUN=01, CLEAR=11, RESP=10.
  - XLEN.
- One natural sub-module, rv32m_sign_fix: combinational operand magnitude, neg flag and 64-bit conditional negation. The FSM, counter and response registers stay in the top module.

Test Plan:
- MUL 7 × (−3) (rs1=0x00000007, rs2=0xFFFFFFFD) → mult_op_b_o=3, rsp_data_o=0xFFFFFFEB, err=0, rsp_valid_o 10 cycles after accept, mult_rst_o pulsed once.
- MULH 0x80000000 × 0x80000000 → magnitudes 0x80000000 each, neg=0, rsp_data_o=0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → A=−1 (signed), B=4294967295 (unsigned), rsp_data_o=0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- MUL rs1=0, rs2=0x1234 → response 1 cycle after accept, data 0, mult_en_o never asserted. DIV funct3=100 → err=1, data 0.
- Multiplier model that never raises done → after TIMEOUT_CYCLES RUN cycles: CLEAR pulse, then rsp_err_o=1. Hold rsp_ready_i=0 for 5 cycles → outputs stable, req_ready_o=0.
- Assert rst_ni low during the 4th RUN cycle → immediate IDLE, mult_en_o=0, mult_rst_o=1 while in reset, no response. A fresh MULHU 3×5 afterwards → 0x00000000, rd echoed.

Source files
------------

// File: rtl/rv32m_mul_issue_pkg.sv
// Shared definitions for the RV32M multiply issue block: funct3 codes,
// FSM state encoding and the default datapath width.
package rv32m_mul_issue_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b11,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/rv32m_sign_fix.sv
// Operand magnitude extraction and product sign correction around an
// unsigned multiplier. Purely combinational.
module rv32m_sign_fix
  import rv32m_mul_issue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [XLEN-1:0]   mag_a_o,
  output logic [XLEN-1:0]   mag_b_o,
  output logic              neg_o,
  input  logic              neg_i,
  input  logic [2*XLEN-1:0] prod_i,
  output logic [2*XLEN-1:0] prod_fix_o
);

  logic a_signed;
  logic b_signed;
  logic a_neg;
  logic b_neg;

  always_comb begin
    a_signed = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
    b_signed = (funct3_i == F3_MUL) || (funct3_i == F3_MULH);
    a_neg    = a_signed & rs1_i[XLEN-1];
    b_neg    = b_signed & rs2_i[XLEN-1];
    // The most negative value negates to itself, which is the correct unsigned magnitude.
    mag_a_o  = a_neg ? (~rs1_i + XLEN'(1)) : rs1_i;
    mag_b_o  = b_neg ? (~rs2_i + XLEN'(1)) : rs2_i;
    neg_o    = a_neg ^ b_neg;
    prod_fix_o = neg_i ? (~prod_i + (2*XLEN)'(1)) : prod_i;
  end

endmodule

// File: rtl/rv32m_mul_issue.sv
// Requester side of the multiplier handshake: accepts RV32M multiply requests,
// runs the unsigned multiplier, sign-corrects the product and responds.
module rv32m_mul_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned XLEN           = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_rs1_i,
  input  logic [XLEN-1:0]   req_rs2_i,
  input  logic [4:0]        req_rd_i,
  output logic              mult_en_o,
  output logic              mult_rst_o,
  output logic [XLEN-1:0]   mult_op_a_o,
  output logic [XLEN-1:0]   mult_op_b_o,
  input  logic              mult_done_i,
  input  logic [2*XLEN-1:0] mult_prod_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_err_o
);

  import rv32m_mul_issue_pkg::*;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     op_a_q;
  logic [XLEN-1:0]     op_b_q;
  logic                neg_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     data_q;
  logic                err_q;

  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                neg;
  logic [2*XLEN-1:0]   prod_fix;
  logic                shortcut;
  logic                timeout;

  rv32m_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .funct3_i   (req_funct3_i),
    .rs1_i      (req_rs1_i),
    .rs2_i      (req_rs2_i),
    .mag_a_o    (mag_a),
    .mag_b_o    (mag_b),
    .neg_o      (neg),
    .neg_i      (neg_q),
    .prod_i     (mult_prod_i),
    .prod_fix_o (prod_fix)
  );

  always_comb begin
    state_d  = state_q;
    shortcut = req_funct3_i[2] || (req_rs1_i == '0) || (req_rs2_i == '0);
    timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    unique case (state_q)
      ST_IDLE:  if (req_valid_i) state_d = shortcut ? ST_RESP : ST_RUN;
      ST_RUN:   if (mult_done_i || timeout) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      funct3_q <= '0;
      rd_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid_i) begin
          funct3_q <= req_funct3_i;
          rd_q     <= req_rd_i;
          neg_q    <= neg;
          cnt_q    <= '0;
          data_q   <= '0;
          err_q    <= req_funct3_i[2];
          // Operands only change when the multiplier will actually run.
          if (!shortcut) begin
            op_a_q <= mag_a;
            op_b_q <= mag_b;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (mult_done_i) begin
            data_q <= (funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            err_q  <= 1'b0;
          end else if (timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = rst_ni && (state_q == ST_IDLE);
  assign mult_en_o   = (state_q == ST_RUN);
  assign mult_rst_o  = !rst_ni || (state_q == ST_CLEAR);
  assign mult_op_a_o = op_a_q;
  assign mult_op_b_o = op_b_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = data_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_err_o   = err_q;

endmodule
